// File: rtl/rgb2raw_12.sv
// Bayer re-mosaicer: turns a 24-bit RGB stream back into 12-bit raw Bayer samples,
// packed two per word (even-x pixel in the upper lane) for replay through the de-Bayer.
module rgb2raw_12 #(
   parameter int unsigned LINE_PIXELS = 1280,
   parameter int unsigned FRAME_LINES = 720,
   parameter int unsigned RGB_WIDTH   = 24
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [RGB_WIDTH-1:0] rgb_in,
   input  logic                 rgb_valid,
   input  logic                 rgb_sof,
   output logic                 rgb_ready,
   output logic [23:0]          data_out,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 line_last,
   output logic                 frame_last,
   output logic                 resync
);

   localparam int unsigned XW = (LINE_PIXELS > 2) ? $clog2(LINE_PIXELS) : 1;
   localparam int unsigned YW = (FRAME_LINES > 2) ? $clog2(FRAME_LINES) : 1;
   localparam logic [XW-1:0] XLast = XW'(LINE_PIXELS - 1);
   localparam logic [YW-1:0] YLast = YW'(FRAME_LINES - 1);

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] ACTIVE = 1'b1;

   if (LINE_PIXELS % 2 != 0) begin : g_bad_line
      $error("rgb2raw_12: LINE_PIXELS must be even");
   end
   if (FRAME_LINES < 2) begin : g_bad_frame
      $error("rgb2raw_12: FRAME_LINES must be at least 2");
   end
   if (RGB_WIDTH != 24) begin : g_bad_width
      $error("rgb2raw_12: only RGB_WIDTH=24 is supported");
   end

   logic [0:0]    state_q;
   logic [XW-1:0] x_q;
   logic [YW-1:0] y_q;
   logic          phase_q;
   logic [11:0]   hold_q;

   logic          accept;
   logic          take;
   logic          drop;
   logic          load;
   logic [XW-1:0] eff_x;
   logic [YW-1:0] eff_y;
   logic          eff_phase;
   logic          x_end;
   logic          y_end;
   logic [7:0]    c8;
   logic [11:0]   sample;

   // Only a completing (phase=1) pixel needs room in the output register.
   assign rgb_ready = (state_q == IDLE) | ~phase_q | ~data_valid | data_ready;
   assign accept    = rgb_valid & rgb_ready;
   assign take      = accept & ((state_q == ACTIVE) | rgb_sof);
   assign drop      = accept & rgb_sof & (state_q == ACTIVE) & phase_q;

   // Any sof restarts the frame, so the pixel is always treated as x=0, y=0.
   assign eff_x     = rgb_sof ? '0 : x_q;
   assign eff_y     = rgb_sof ? '0 : y_q;
   assign eff_phase = rgb_sof ? 1'b0 : phase_q;
   assign x_end     = (eff_x == XLast);
   assign y_end     = (eff_y == YLast);
   assign load      = take & eff_phase;

   always_comb begin
      c8 = rgb_in[15:8];
      if (eff_y[0]) begin
         c8 = eff_x[0] ? rgb_in[15:8] : rgb_in[23:16];
      end else begin
         c8 = eff_x[0] ? rgb_in[7:0] : rgb_in[15:8];
      end
   end

   assign sample = {c8, c8[7:4]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         x_q        <= '0;
         y_q        <= '0;
         phase_q    <= 1'b0;
         hold_q     <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         line_last  <= 1'b0;
         frame_last <= 1'b0;
         resync     <= 1'b0;
      end else begin
         resync <= drop;

         if (take) begin
            if (!eff_phase) begin
               hold_q  <= sample;
               phase_q <= 1'b1;
            end else begin
               phase_q <= 1'b0;
            end

            if (x_end) begin
               x_q <= '0;
               y_q <= y_end ? '0 : eff_y + 1'b1;
            end else begin
               x_q <= eff_x + 1'b1;
               y_q <= eff_y;
            end

            state_q <= (x_end && y_end) ? IDLE : ACTIVE;
         end

         if (load) begin
            data_out   <= {hold_q, sample};
            data_valid <= 1'b1;
            line_last  <= x_end;
            frame_last <= x_end & y_end;
         end else if (data_ready) begin
            data_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rgb2raw_12.sv
// Self-checking bench for rgb2raw_12 on a small 4x2 frame, with a frame-index reference model.
module tb_rgb2raw_12;

   localparam int LP = 4;
   localparam int FL = 2;

   logic        clk;
   logic        rst_n;
   logic [23:0] rgb_in;
   logic        rgb_valid;
   logic        rgb_sof;
   logic        rgb_ready;
   logic [23:0] data_out;
   logic        data_valid;
   logic        data_ready;
   logic        line_last;
   logic        frame_last;
   logic        resync;

   int checks;
   int failures;

   // Reference model state: position as a linear pixel index within the frame.
   bit          m_active;
   int          m_n;
   logic [11:0] m_hold;
   logic [25:0] exp_q[$];
   logic [25:0] got_q[$];
   int          exp_resync;
   int          resync_seen;
   bit          rand_bp;

   rgb2raw_12 #(
      .LINE_PIXELS(LP),
      .FRAME_LINES(FL),
      .RGB_WIDTH  (24)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rgb_in    (rgb_in),
      .rgb_valid (rgb_valid),
      .rgb_sof   (rgb_sof),
      .rgb_ready (rgb_ready),
      .data_out  (data_out),
      .data_valid(data_valid),
      .data_ready(data_ready),
      .line_last (line_last),
      .frame_last(frame_last),
      .resync    (resync)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n && data_valid && data_ready) got_q.push_back({line_last, frame_last, data_out});
      if (resync) resync_seen++;
   end

   always @(posedge clk) begin
      #1;
      if (rand_bp) data_ready = 1'($urandom_range(0, 1));
   end

   function automatic void model_accept(input logic [23:0] p, input logic s);
      int          x;
      int          y;
      logic [7:0]  c;
      logic [11:0] s12;
      if (!m_active && !s) return;
      if (s) begin
         if (m_active && (m_n % 2 == 1)) exp_resync++;
         m_n      = 0;
         m_active = 1;
      end
      x = m_n % LP;
      y = m_n / LP;
      if (y % 2 == 0) c = (x % 2 == 0) ? p[15:8] : p[7:0];
      else            c = (x % 2 == 0) ? p[23:16] : p[15:8];
      s12 = 12'(c * 16 + c / 16);
      if (x % 2 == 1) exp_q.push_back({(x == LP - 1), (x == LP - 1) && (y == FL - 1), m_hold, s12});
      else m_hold = s12;
      m_n++;
      if (m_n == LP * FL) begin
         m_n      = 0;
         m_active = 0;
      end
   endfunction

   task automatic do_reset();
      rst_n      = 1'b0;
      rgb_valid  = 1'b0;
      rgb_sof    = 1'b0;
      rgb_in     = '0;
      data_ready = 1'b0;
      rand_bp    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      m_active    = 0;
      m_n         = 0;
      m_hold      = '0;
      exp_resync  = 0;
      resync_seen = 0;
      exp_q.delete();
      got_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic send(input logic [23:0] p, input logic s);
      bit   ok;
      logic acc;
      ok = 0;
      @(posedge clk);
      #1;
      rgb_in    = p;
      rgb_sof   = s;
      rgb_valid = 1'b1;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         acc = rgb_ready;
         @(posedge clk);
         #1;
         if (acc) ok = 1;
      end
      rgb_valid = 1'b0;
      rgb_sof   = 1'b0;
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL send_timeout: pixel %h not accepted, required acceptance within 50 cycles", p);
      end else begin
         model_accept(p, s);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      rgb_valid = 1'b0; rgb_sof = 1'b0; rgb_in = '0; data_ready = 1'b0; rand_bp = 1'b0;
      #1;
      checks++;
      if ({data_valid, line_last, frame_last, resync} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_flags: got %b required 0000",
                  {data_valid, line_last, frame_last, resync});
      end
      checks++;
      if (data_out !== 24'h0) begin
         failures++;
         $display("FAIL reset_data: got %h required 000000", data_out);
      end
      do_reset();
      checks++;
      if (rgb_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready: got %b required 1", rgb_ready);
      end
   endtask

   task automatic test_line_end();
      logic [1:0] ll_exp [4];
      logic [1:0] fl_exp [4];
      ll_exp = '{2'd0, 2'd1, 2'd0, 2'd1};
      fl_exp = '{2'd0, 2'd0, 2'd0, 2'd1};
      do_reset();
      data_ready = 1'b1;
      send(24'hAB12F0, 1'b1);
      send(24'hAB12F0, 1'b0);
      @(negedge clk);
      checks++;
      if (data_valid !== 1'b1 || data_out !== 24'h121F0F) begin
         failures++;
         $display("FAIL even_pair: got valid=%b data=%h required valid=1 data=121f0f",
                  data_valid, data_out);
      end
      send($urandom, 1'b0);
      send($urandom, 1'b0);
      send(24'hAB12F0, 1'b0);
      send(24'hAB12F0, 1'b0);
      @(negedge clk);
      checks++;
      if (data_out !== 24'hABA121) begin
         failures++;
         $display("FAIL odd_pair: got %h required aba121", data_out);
      end
      send($urandom, 1'b0);
      send($urandom, 1'b0);
      repeat (2) @(negedge clk);
      checks++;
      if (got_q.size() != 4) begin
         failures++;
         $display("FAIL line_end_count: got %0d words required 4", got_q.size());
      end
      for (int i = 0; i < 4 && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i][25] !== ll_exp[i][0] || got_q[i][24] !== fl_exp[i][0]) begin
            failures++;
            $display("FAIL line_end_flags[%0d]: got ll=%b fl=%b required ll=%b fl=%b",
                     i, got_q[i][25], got_q[i][24], ll_exp[i][0], fl_exp[i][0]);
         end
         checks++;
         if (i < exp_q.size() && got_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL line_end_word[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
         end
      end
      send($urandom, 1'b0);
      send($urandom, 1'b0);
      repeat (3) @(negedge clk);
      checks++;
      if (got_q.size() != 4 || data_valid !== 1'b0) begin
         failures++;
         $display("FAIL idle_drop: got words=%0d valid=%b required words=4 valid=0",
                  got_q.size(), data_valid);
      end
   endtask

   task automatic test_backpressure();
      logic [23:0] w;
      do_reset();
      send($urandom, 1'b1);
      send($urandom, 1'b0);
      @(negedge clk);
      w = data_out;
      checks++;
      if (data_valid !== 1'b1 || w !== exp_q[0][23:0]) begin
         failures++;
         $display("FAIL bp_first_word: got valid=%b data=%h required valid=1 data=%h",
                  data_valid, w, exp_q[0][23:0]);
      end
      @(posedge clk);
      #1;
      rgb_in = 24'h5A3C96; rgb_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (rgb_ready !== 1'b1) begin
         failures++;
         $display("FAIL bp_even_ready: got %b required 1", rgb_ready);
      end
      @(posedge clk);
      #1;
      model_accept(24'h5A3C96, 1'b0);
      rgb_in = 24'hC30F81;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (rgb_ready !== 1'b0 || data_valid !== 1'b1 || data_out !== w) begin
            failures++;
            $display("FAIL bp_stall[%0d]: got ready=%b valid=%b data=%h required 0 1 %h",
                     i, rgb_ready, data_valid, data_out, w);
         end
      end
      @(posedge clk);
      #1;
      data_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (rgb_ready !== 1'b1) begin
         failures++;
         $display("FAIL bp_release_ready: got %b required 1", rgb_ready);
      end
      @(posedge clk);
      #1;
      rgb_valid = 1'b0;
      model_accept(24'hC30F81, 1'b0);
      @(negedge clk);
      checks++;
      if (data_valid !== 1'b1 || data_out !== exp_q[1][23:0] || line_last !== 1'b1) begin
         failures++;
         $display("FAIL bp_second_word: got valid=%b data=%h ll=%b required 1 %h 1",
                  data_valid, data_out, line_last, exp_q[1][23:0]);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (got_q.size() != 2 || got_q[0] !== exp_q[0]) begin
         failures++;
         $display("FAIL bp_delivery: got %0d words required 2 (first %h)",
                  got_q.size(), exp_q[0]);
      end
   endtask

   task automatic test_early_sof();
      do_reset();
      data_ready = 1'b1;
      send(24'hAB12F0, 1'b1);
      send(24'h112233, 1'b1);
      @(negedge clk);
      checks++;
      if (resync !== 1'b1) begin
         failures++;
         $display("FAIL resync_pulse: got %b required 1", resync);
      end
      @(negedge clk);
      checks++;
      if (resync !== 1'b0 || data_valid !== 1'b0) begin
         failures++;
         $display("FAIL resync_width: got resync=%b valid=%b required 0 0", resync, data_valid);
      end
      send(24'h445566, 1'b0);
      @(negedge clk);
      checks++;
      if (data_valid !== 1'b1 || data_out !== 24'h222666 || line_last !== 1'b0) begin
         failures++;
         $display("FAIL early_sof_word: got valid=%b data=%h ll=%b required 1 222666 0",
                  data_valid, data_out, line_last);
      end
      @(negedge clk);
      checks++;
      if (got_q.size() != 1 || resync_seen != exp_resync) begin
         failures++;
         $display("FAIL early_sof_totals: got words=%0d resyncs=%0d required 1 %0d",
                  got_q.size(), resync_seen, exp_resync);
      end
   endtask

   task automatic test_random_stream();
      do_reset();
      rand_bp = 1'b1;
      for (int i = 0; i < 60; i++) begin
         send($urandom, (i == 0) || ($urandom_range(0, 9) == 0));
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      end
      rand_bp = 1'b0;
      @(posedge clk);
      #1;
      data_ready = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if (got_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL random_count: got %0d words required %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL random_word[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
         end
      end
      checks++;
      if (resync_seen != exp_resync) begin
         failures++;
         $display("FAIL random_resync: got %0d required %0d", resync_seen, exp_resync);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      send($urandom, 1'b1);
      send($urandom, 1'b0);
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if (data_valid !== 1'b0 || data_out !== 24'h0) begin
         failures++;
         $display("FAIL async_reset: got valid=%b data=%h required 0 000000", data_valid, data_out);
      end
      @(negedge clk);
      rst_n = 1'b1;
      m_active = 0; m_n = 0;
      exp_q.delete();
      got_q.delete();
      data_ready = 1'b1;
      send($urandom, 1'b0);
      send($urandom, 1'b0);
      repeat (3) @(negedge clk);
      checks++;
      if (got_q.size() != 0 || data_valid !== 1'b0 || rgb_ready !== 1'b1) begin
         failures++;
         $display("FAIL post_reset_idle: got words=%0d valid=%b ready=%b required 0 0 1",
                  got_q.size(), data_valid, rgb_ready);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_line_end();
      test_backpressure();
      test_early_sof();
      test_random_stream();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
